// File: rtl/load_hazard_scoreboard.sv
// load_hazard_scoreboard: ordered queue of in-flight load destinations driving the ID read-after-load stall
module load_hazard_scoreboard #(
  parameter int DEPTH = 4,
  parameter int REG_AW = 5,
  parameter int CNT_W = 16,
  parameter int RETIRE_BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid_i,
  input  logic                     issue_is_load_i,
  input  logic [REG_AW-1:0]        issue_rd_i,
  input  logic                     rs1_en_i,
  input  logic [REG_AW-1:0]        rs1_addr_i,
  input  logic                     rs2_en_i,
  input  logic [REG_AW-1:0]        rs2_addr_i,
  input  logic                     commit_i,
  input  logic                     retire_i,
  input  logic                     flush_i,
  output logic                     stall_o,
  output logic [REG_AW-1:0]        head_rd_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [CNT_W-1:0]         stall_cycles_o,
  output logic                     err_o
);
  localparam int PW = $clog2(DEPTH);
  logic [PW:0] head_q, head_d, cptr_q, cptr_d, tail_q, tail_d;
  logic [REG_AW-1:0] rd_q [DEPTH];
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic err_q, err_d;
  logic match1, match2, com_ok, ret_ok, alloc, v;
  logic [PW-1:0] off;
  assign count_o = tail_q - head_q;
  assign full_o = (head_q[PW-1:0] == tail_q[PW-1:0]) & (head_q[PW] != tail_q[PW]);
  assign empty_o = head_q == tail_q;
  assign head_rd_o = empty_o ? '0 : rd_q[head_q[PW-1:0]];
  assign stall_cycles_o = stall_cycles_q;
  assign err_o = err_q;
  // Compare both sources against every live entry; a retiring head is forwarded from MEM instead
  always_comb begin
    match1 = 1'b0;
    match2 = 1'b0;
    off = '0;
    v = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head_q[PW-1:0];
      v = ({1'b0, off} < count_o) & ~((RETIRE_BYPASS != 0) & retire_i & (off == '0));
      match1 = match1 | (v & rs1_en_i & (rs1_addr_i != '0) & (rd_q[i] == rs1_addr_i));
      match2 = match2 | (v & rs2_en_i & (rs2_addr_i != '0) & (rd_q[i] == rs2_addr_i));
    end
    stall_o = issue_valid_i & (match1 | match2 | (issue_is_load_i & full_o & ~retire_i));
  end
  // Pointer updates: commit, then retire against the post-commit cptr, then flush rewinds tail
  always_comb begin
    com_ok = commit_i & (cptr_q != tail_q);
    cptr_d = cptr_q + (PW+1)'(com_ok);
    ret_ok = retire_i & (head_q != cptr_d);
    head_d = head_q + (PW+1)'(ret_ok);
    alloc = issue_valid_i & issue_is_load_i & (issue_rd_i != '0) & ~stall_o & ~flush_i & (~full_o | ret_ok);
    tail_d = flush_i ? cptr_d : tail_q + (PW+1)'(alloc);
    err_d = err_q | (commit_i & ~com_ok) | (retire_i & ~ret_ok);
    stall_cycles_d = (stall_o & ~&stall_cycles_q) ? stall_cycles_q + 1'b1 : stall_cycles_q;
  end
  // Control state with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      cptr_q <= '0;
      tail_q <= '0;
      stall_cycles_q <= '0;
      err_q <= 1'b0;
    end else begin
      head_q <= head_d;
      cptr_q <= cptr_d;
      tail_q <= tail_d;
      stall_cycles_q <= stall_cycles_d;
      err_q <= err_d;
    end
  end
  // Destination storage; contents only matter between head and tail
  always_ff @(posedge clk) begin
    if (alloc) rd_q[tail_q[PW-1:0]] <= issue_rd_i;
  end
endmodule

// File: tb/tb_load_hazard_scoreboard.sv
// tb_load_hazard_scoreboard: directed scoreboard bench for load_hazard_scoreboard
module tb_load_hazard_scoreboard;
  logic clk = 1'b0, rst_n = 1'b0;
  logic issue_valid_i = 0, issue_is_load_i = 0, rs1_en_i = 0, rs2_en_i = 0;
  logic [4:0] issue_rd_i = 0, rs1_addr_i = 0, rs2_addr_i = 0;
  logic commit_i = 0, retire_i = 0, flush_i = 0;
  logic stall_o, full_o, empty_o, err_o;
  logic [4:0] head_rd_o;
  logic [2:0] count_o;
  logic [15:0] stall_cycles_o;
  int n_run = 0, n_fail = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  load_hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid_i(issue_valid_i), .issue_is_load_i(issue_is_load_i), .issue_rd_i(issue_rd_i),
    .rs1_en_i(rs1_en_i), .rs1_addr_i(rs1_addr_i), .rs2_en_i(rs2_en_i), .rs2_addr_i(rs2_addr_i),
    .commit_i(commit_i), .retire_i(retire_i), .flush_i(flush_i),
    .stall_o(stall_o), .head_rd_o(head_rd_o), .count_o(count_o), .full_o(full_o),
    .empty_o(empty_o), .stall_cycles_o(stall_cycles_o), .err_o(err_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid_i = 0; issue_is_load_i = 0; issue_rd_i = 0;
    rs1_en_i = 0; rs1_addr_i = 0; rs2_en_i = 0; rs2_addr_i = 0;
    commit_i = 0; retire_i = 0; flush_i = 0;
  endtask

  task automatic load(input logic [4:0] rd);
    idle();
    issue_valid_i = 1; issue_is_load_i = 1; issue_rd_i = rd;
  endtask

  task automatic alu(input logic [4:0] a, input logic [4:0] b);
    idle();
    issue_valid_i = 1; rs1_en_i = 1; rs1_addr_i = a; rs2_en_i = 1; rs2_addr_i = b;
  endtask

  task automatic expect_v(input logic [31:0] e);
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_run++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=<none queued>", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
      end
    end
  endtask

  initial begin
    #1;
    expect_v(0); chk("rst_count", 32'(count_o));
    expect_v(1); chk("rst_empty", 32'(empty_o));
    expect_v(0); chk("rst_full", 32'(full_o));
    expect_v(0); chk("rst_head_rd", 32'(head_rd_o));
    expect_v(0); chk("rst_stall", 32'(stall_o));
    expect_v(0); chk("rst_err", 32'(err_o));
    expect_v(0); chk("rst_stall_cycles", 32'(stall_cycles_o));
    step(); rst_n = 1; step();
    load(5); #1;
    expect_v(0); chk("t1_load_stall", 32'(stall_o));
    step();
    alu(5, 3); #1;
    expect_v(1); chk("t1_raw_stall", 32'(stall_o));
    expect_v(1); chk("t1_count1", 32'(count_o));
    expect_v(5); chk("t1_head_rd", 32'(head_rd_o));
    step();
    idle(); commit_i = 1; #1;
    expect_v(1); chk("t1_stall_cycles", 32'(stall_cycles_o));
    step();
    alu(5, 3); retire_i = 1; #1;
    expect_v(0); chk("t1_bypass_stall", 32'(stall_o));
    step();
    idle(); #1;
    expect_v(0); chk("t1_count0", 32'(count_o));
    load(0); step();
    alu(0, 0); #1;
    expect_v(0); chk("t2_rd0_stall", 32'(stall_o));
    expect_v(0); chk("t2_rd0_count", 32'(count_o));
    for (int i = 1; i <= 4; i++) begin
      load(5'(i)); step();
    end
    idle(); #1;
    expect_v(1); chk("t3_full", 32'(full_o));
    expect_v(4); chk("t3_count4", 32'(count_o));
    commit_i = 1; step();
    load(6); #1;
    expect_v(1); chk("t3_full_stall", 32'(stall_o));
    retire_i = 1; #1;
    expect_v(0); chk("t3_retire_stall", 32'(stall_o));
    step();
    idle(); #1;
    expect_v(4); chk("t3_count_stays4", 32'(count_o));
    expect_v(2); chk("t3_head_rd2", 32'(head_rd_o));
    for (int i = 0; i < 4; i++) begin
      commit_i = 1; retire_i = 1; step();
    end
    idle(); #1;
    expect_v(1); chk("t3_drained", 32'(empty_o));
    expect_v(0); chk("t3_err", 32'(err_o));
    load(7); step(); load(8); step(); load(9); step();
    idle(); commit_i = 1; step();
    idle(); flush_i = 1; step();
    idle(); #1;
    expect_v(1); chk("t4_flush_count", 32'(count_o));
    expect_v(7); chk("t4_flush_head", 32'(head_rd_o));
    alu(8, 0); #1;
    expect_v(0); chk("t4_flushed_rd8", 32'(stall_o));
    alu(7, 0); #1;
    expect_v(1); chk("t4_kept_rd7", 32'(stall_o));
    idle(); retire_i = 1; step();
    idle(); #1;
    expect_v(0); chk("t4_count0", 32'(count_o));
    expect_v(0); chk("t4_err", 32'(err_o));
    retire_i = 1; step();
    idle(); #1;
    expect_v(1); chk("t5_err_set", 32'(err_o));
    expect_v(0); chk("t5_count", 32'(count_o));
    step();
    expect_v(1); chk("t5_err_sticky", 32'(err_o));
    load(5); step();
    alu(5, 0);
    for (int i = 0; i < 70000; i++) step();
    expect_v(1); chk("t6_stall_held", 32'(stall_o));
    expect_v(65535); chk("t6_saturated", 32'(stall_cycles_o));
    #2 rst_n = 0; #1;
    expect_v(0); chk("t6_rst_stall", 32'(stall_o));
    expect_v(0); chk("t6_rst_count", 32'(count_o));
    expect_v(1); chk("t6_rst_empty", 32'(empty_o));
    expect_v(0); chk("t6_rst_head_rd", 32'(head_rd_o));
    expect_v(0); chk("t6_rst_cycles", 32'(stall_cycles_o));
    expect_v(0); chk("t6_rst_err", 32'(err_o));
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
